serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Multi-cycle, parametrised add/subtract unit and the sequential successor of the team's 5-bit combinational ripple adder. It processes operands SLICE bits per clock through a single small ripple slice, which trades latency for area. It adds subtract mode, signed-overflow detection and a start/done handshake. It sits beside the datapath as a shared arithmetic resource for wide operands.

Parameters:
WIDTH, 8, operand and result width in bits; must be ≥ 2.
SLICE, 1, bits processed per cycle; must divide WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only while ready=1
sub  input  1  0 = a+b, 1 = a−b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
ready  output  1  high when idle and able to accept start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result; held until the next accepted start
cout  output  1  carry out of the MSB (for subtract: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: the following are sampled at any rising edge with rst=1, including mid-operation; an in-flight operation is aborted with no done pulse.
  - state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0.
  - Operand registers and slice counter cleared.
- FSM states:
  - IDLE: when start=1, go to RUN.
  - RUN: when the slice counter reaches N−1, where N=WIDTH/SLICE, go to IDLE.
- Accept at edge T (start=1, ready=1):
  - Latch a into opA and b^{WIDTH{sub}} into opB.
  - carry := sub; cnt := 0; sum := 0; cout := 0; ovf := 0.
  - busy=1 and ready=0 from T+1.
- RUN, at each edge:
  - The slice adder adds opA[SLICE−1:0], opB[SLICE−1:0] and carry.
  - The result slice shifts in from the MSB end of the sum shift register; opA and opB shift right by SLICE.
  - carry := slice carry-out; cnt++.
- Final RUN edge (edge T+N):
  - cout := slice carry-out.
  - ovf := slice carry-out XOR carry into the top bit of that slice (the slice reports it).
  - sum now holds the LSB-aligned result.
  - Registered outputs: done=1, busy=0, ready=1 in cycle T+N..T+N+1.
- Latency: N cycles from accept edge to the done cycle. WIDTH=8/SLICE=1 gives 8; SLICE=4 gives 2; SLICE=WIDTH gives 1.
- done is high for exactly one cycle.
- start in the done cycle is accepted, so back-to-back operations run with no bubble; throughput is one operation per N cycles.
- start while busy is ignored. Operand and sub changes while busy have no effect.
- sum is not valid while busy and may show partial shift contents. It is stable from the done cycle until the next accept.
- Arithmetic is modulo 2^WIDTH. There is no saturation. cout and ovf are both always reported; the consumer selects unsigned or signed interpretation.

Decomposition:
- Shared package addsub_pkg:
  - state enum {IDLE, RUN}.
  - Function clog2 for the counter width, $clog2(N) with a minimum of 1.
- Sub-module addsub_slice, parametrised SLICE: combinational SLICE-bit ripple of full adders.
  - Inputs: x, y, cin.
  - Outputs: s, cout, and c_top, the carry into the top bit of the slice.
- All sequencing and registers stay in serial_addsub.

Test Plan:
1. WIDTH=8, SLICE=1: sub=0, a=25, b=6, start pulse at edge T → busy high for 8 cycles; done only at T+8; sum=31, cout=0, ovf=0; ready=1 in the done cycle.
2. WIDTH=8: a=200, b=100, add → sum=44 (0x2C), cout=1, ovf=0. Then a=100, b=100 → sum=200 (0xC8), cout=0, ovf=1.
3. WIDTH=8: sub=1, a=5, b=7 → sum=0xFE, cout=0. Then sub=1, a=0x80, b=1 → sum=0x7F, cout=1, ovf=1.
4. Handshake: start held high throughout plus operand change mid-run → only the first operands are used; start in the done cycle launches op 2 with done 8 cycles later; no done pulse in between.
5. Reset: rst=1 at cycle 3 of a run → next cycle idle, ready=1, sum=0, and no done pulse; a fresh start afterwards completes correctly.
6. WIDTH=16, SLICE=4: a=0xFFFF, b=1, add → done 4 cycles after accept, sum=0x0000, cout=1, ovf=0. Random sweep checks all results against a+b and a−b.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial add/subtract unit.
// Holds the sequencer state enum and the counter-width helper.
package addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter width for n slices, never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit ripple of full adders.
// Ports: x, y, cin in; s, cout, c_top (carry into the top bit) out.
module addsub_slice #(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_top
);

  logic c;

  always_comb begin
    s     = '0;
    c_top = 1'b0;
    c     = cin;
    for (int i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) c_top = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract, SLICE bits per clock, start/done handshake.
// Ports: clk, rst, start, sub, a, b in; ready, busy, done, sum, cout, ovf out.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] sl_s;
  logic             sl_cout;
  logic             sl_ctop;
  logic [WIDTH+SLICE-1:0] shift_cat;

  addsub_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .x    (opa_q[SLICE-1:0]),
    .y    (opb_q[SLICE-1:0]),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_cout),
    .c_top(sl_ctop)
  );

  // New slice enters at the MSB end; works for SLICE == WIDTH too.
  assign shift_cat = {sl_s, sum_q};

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        opa_d   = opa_q >> SLICE;
        opb_d   = opb_q >> SLICE;
        sum_d   = shift_cat[WIDTH+SLICE-1:SLICE];
        carry_d = sl_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cout_d  = sl_cout;
          ovf_d   = sl_cout ^ sl_ctop;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and swept checks of serial_addsub.
// Two instances: WIDTH=8/SLICE=1 and WIDTH=16/SLICE=4.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;

  logic       start8, sub8;
  logic [7:0] a8, b8, sum8;
  logic       ready8, busy8, done8, cout8, ovf8;

  logic        start16, sub16;
  logic [15:0] a16, b16, sum16;
  logic        ready16, busy16, done16, cout16, ovf16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .SLICE(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8),
    .a(a8), .b(b8), .ready(ready8), .busy(busy8),
    .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16),
    .a(a16), .b(b16), .ready(ready16), .busy(busy16),
    .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from integer arithmetic.
  function automatic logic [17:0] model(input int w, input int a,
                                        input int b, input bit sub);
    int full, half, sa, sb, r, u, s;
    bit c, o;
    full = 1 << w;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    r  = sub ? sa - sb : sa + sb;
    u  = sub ? a - b : a + b;
    s  = ((u % full) + full) % full;
    c  = sub ? (a >= b) : (a + b >= full);
    o  = (r >= half) || (r < -half);
    return {o, c, 16'(s)};
  endfunction

  task automatic launch8(input bit s, input logic [7:0] a,
                         input logic [7:0] b);
    start8 = 1'b1; sub8 = s; a8 = a; b8 = b;
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic wait8(input string tag, input logic [7:0] es,
                       input bit ec, input bit eo);
    int k;
    bit seen;
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        seen = 1'b1;
        break;
      end
      chk({tag, ".busy"}, 32'(busy8), 32'd1);
      chk({tag, ".rdy0"}, 32'(ready8), 32'd0);
    end
    chk({tag, ".done"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, ".lat"}, 32'(k), 32'd8);
      chk({tag, ".sum"}, 32'(sum8), 32'(es));
      chk({tag, ".cout"}, 32'(cout8), 32'(ec));
      chk({tag, ".ovf"}, 32'(ovf8), 32'(eo));
      chk({tag, ".rdy"}, 32'(ready8), 32'd1);
      chk({tag, ".nbusy"}, 32'(busy8), 32'd0);
    end
  endtask

  task automatic run8(input string tag, input bit s,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] es, input bit ec, input bit eo);
    launch8(s, a, b);
    a8 = ~a; b8 = ~b; sub8 = ~s;
    wait8(tag, es, ec, eo);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(done8), 32'd0);
  endtask

  task automatic run16(input string tag, input bit s,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] es, input bit ec, input bit eo);
    int k;
    bit seen;
    start16 = 1'b1; sub16 = s; a16 = a; b16 = b;
    @(posedge clk);
    #1 start16 = 1'b0;
    a16 = ~a;
    seen = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done16) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, ".done"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, ".lat"}, 32'(k), 32'd4);
      chk({tag, ".sum"}, 32'(sum16), 32'(es));
      chk({tag, ".cout"}, 32'(cout16), 32'(ec));
      chk({tag, ".ovf"}, 32'(ovf16), 32'(eo));
    end
  endtask

  initial begin
    logic [17:0] m;
    logic [7:0]  ra, rb;
    logic [15:0] qa, qb;
    bit          rs;
    int          spur;

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", 32'(ready8), 32'd1);
    chk("rst.busy", 32'(busy8), 32'd0);
    chk("rst.done", 32'(done8), 32'd0);
    chk("rst.sum", 32'(sum8), 32'd0);
    chk("rst.cout", 32'(cout8), 32'd0);
    chk("rst.ovf", 32'(ovf8), 32'd0);
    chk("rst.ready16", 32'(ready16), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    run8("add25_6", 1'b0, 8'd25, 8'd6, 8'd31, 1'b0, 1'b0);
    run8("add200_100", 1'b0, 8'd200, 8'd100, 8'h2C, 1'b1, 1'b0);
    run8("add100_100", 1'b0, 8'd100, 8'd100, 8'hC8, 1'b0, 1'b1);
    run8("sub5_7", 1'b1, 8'd5, 8'd7, 8'hFE, 1'b0, 1'b0);
    run8("sub80_1", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Start held high, operands change mid-run, op 2 in the done cycle.
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'd10; b8 = 8'd20;
    @(posedge clk);
    #1 sub8 = 1'b1; a8 = 8'h70; b8 = 8'h30;
    wait8("b2b1", 8'd30, 1'b0, 1'b0);
    @(posedge clk);
    #1 start8 = 1'b0;
    wait8("b2b2", 8'h40, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);

    // Reset in the third cycle of a run.
    launch8(1'b0, 8'h33, 8'h11);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort.ready", 32'(ready8), 32'd1);
    chk("abort.busy", 32'(busy8), 32'd0);
    chk("abort.sum", 32'(sum8), 32'd0);
    spur = 0;
    if (done8) spur++;
    repeat (12) begin
      @(negedge clk);
      if (done8) spur++;
    end
    chk("abort.nodone", 32'(spur), 32'd0);
    run8("fresh", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

    run16("w16ffff", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run16("w16sub", 1'b1, 16'h1234, 16'h0235, 16'h0FFF, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom());
      rb = 8'($urandom());
      rs = 1'($urandom());
      m  = model(8, int'(ra), int'(rb), rs);
      run8("rnd8", rs, ra, rb, m[7:0], m[16], m[17]);
    end
    for (int i = 0; i < 12; i++) begin
      qa = 16'($urandom());
      qb = 16'($urandom());
      rs = 1'($urandom());
      m  = model(16, int'(qa), int'(qb), rs);
      run16("rnd16", rs, qa, qb, m[15:0], m[16], m[17]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
